// File: rtl/mpq_sched_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mpq_sched_if : loader, requester and engine signals of mpq_sched        |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
interface mpq_sched_if;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       q0_push;
    logic [2:0] q0_cmd;
    logic [7:0] q0_index;
    logic [7:0] q0_value;
    logic       q1_push;
    logic [2:0] q1_cmd;
    logic [7:0] q1_index;
    logic [7:0] q1_value;
    logic       q0_full;
    logic       q1_full;
    logic       q0_ovf;
    logic       q1_ovf;
    logic       mpq_data_valid;
    logic [7:0] mpq_data;
    logic       mpq_cmd_valid;
    logic [2:0] mpq_cmd;
    logic [7:0] mpq_index;
    logic [7:0] mpq_value;
    logic       mpq_busy;
    logic       mpq_done;
    logic       grant_src;
    logic       finished;

    modport slave (
        input  ld_valid, ld_data,
        input  q0_push, q0_cmd, q0_index, q0_value,
        input  q1_push, q1_cmd, q1_index, q1_value,
        input  mpq_busy, mpq_done,
        output q0_full, q1_full, q0_ovf, q1_ovf,
        output mpq_data_valid, mpq_data,
        output mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value,
        output grant_src, finished
    );

    modport master (
        output ld_valid, ld_data,
        output q0_push, q0_cmd, q0_index, q0_value,
        output q1_push, q1_cmd, q1_index, q1_value,
        output mpq_busy, mpq_done,
        input  q0_full, q1_full, q0_ovf, q1_ovf,
        input  mpq_data_valid, mpq_data,
        input  mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value,
        input  grant_src, finished
    );
endinterface
`default_nettype wire

// File: rtl/mpq_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mpq_sched : two-requester round-robin command scheduler for a PQ engine |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module mpq_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    mpq_sched_if.slave bus
);
    localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = c_PW + 1;
    localparam int c_EW = 19;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_LOAD      = 3'd0,
        S_IDLE      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_HI   = 3'd3,
        S_WAIT_LO   = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_FINISHED  = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_push  [2];
    logic [c_EW-1:0] w_entry [2];
    logic            w_pop   [2];
    logic            w_ne    [2];
    logic            w_full  [2];
    logic            w_ovf   [2];
    logic [c_EW-1:0] w_head  [2];
    logic            w_clear;
    logic            w_sel;
    logic            w_go;
    logic            r_grant;
    logic            r_prio;
    logic            r_seen;
    logic            r_data_valid;
    logic [7:0]      r_data;
    logic [2:0]      r_cmd;
    logic [7:0]      r_index;
    logic [7:0]      r_value;

    assign w_push[0]  = bus.q0_push;
    assign w_push[1]  = bus.q1_push;
    assign w_entry[0] = {bus.q0_cmd, bus.q0_index, bus.q0_value};
    assign w_entry[1] = {bus.q1_cmd, bus.q1_index, bus.q1_value};
    assign w_clear    = (r_state == S_FINISHED);

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fifo
            logic [c_EW-1:0] r_mem [FIFO_DEPTH];
            logic [c_PW-1:0] r_wr_ptr;
            logic [c_PW-1:0] r_rd_ptr;
            logic [c_CW-1:0] r_count;
            logic            r_ovf;
            logic            w_full_q;
            logic            w_wr;

            assign w_full_q = (r_count == c_FULL);
            // A push against a full FIFO is lost even if a pop frees a slot this cycle.
            assign w_wr     = w_push[g] && !w_full_q && !w_clear;
            assign w_pop[g] = (r_state == S_ISSUE) && (r_grant == 1'(g));
            assign w_ne[g]   = (r_count != '0);
            assign w_full[g] = w_full_q;
            assign w_ovf[g]  = r_ovf;
            assign w_head[g] = r_mem[r_rd_ptr];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                    r_ovf    <= 1'b0;
                end else if (w_clear) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[g] && w_full_q)
                        r_ovf <= 1'b1;
                    if (w_wr)
                        r_wr_ptr <= r_wr_ptr + c_PW'(1);
                    if (w_pop[g])
                        r_rd_ptr <= r_rd_ptr + c_PW'(1);
                    if (w_wr && !w_pop[g])
                        r_count <= r_count + c_CW'(1);
                    else if (!w_wr && w_pop[g])
                        r_count <= r_count - c_CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (w_wr)
                    r_mem[r_wr_ptr] <= w_entry[g];
            end
        end
    endgenerate

    // r_prio names the requester that wins when both FIFOs hold work.
    assign w_sel = (w_ne[0] && w_ne[1]) ? r_prio : w_ne[1];
    assign w_go  = (r_state == S_IDLE) && !bus.mpq_busy && (w_ne[0] || w_ne[1]);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_LOAD;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:      if (r_seen && !bus.ld_valid) w_state_next = S_IDLE;
            S_IDLE:      if (w_go) w_state_next = S_ISSUE;
            S_ISSUE:     w_state_next = S_WAIT_HI;
            S_WAIT_HI:   if (bus.mpq_busy) w_state_next = r_cmd[2] ? S_WAIT_DONE : S_WAIT_LO;
            S_WAIT_LO:   if (!bus.mpq_busy) w_state_next = S_IDLE;
            S_WAIT_DONE: if (bus.mpq_done) w_state_next = S_FINISHED;
            S_FINISHED:  w_state_next = S_FINISHED;
            default:     w_state_next = S_LOAD;
        endcase
    end

    // Command fields are captured on entry to ISSUE and then hold until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen       <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_grant      <= 1'b0;
            r_prio       <= 1'b0;
            r_cmd        <= '0;
            r_index      <= '0;
            r_value      <= '0;
        end else begin
            r_data_valid <= (r_state == S_LOAD) && bus.ld_valid;
            if (r_state == S_LOAD) begin
                r_data <= bus.ld_data;
                if (bus.ld_valid)
                    r_seen <= 1'b1;
            end
            if (w_go) begin
                r_grant                   <= w_sel;
                r_prio                    <= ~w_sel;
                {r_cmd, r_index, r_value} <= w_head[w_sel];
            end
        end
    end

    assign bus.q0_full        = w_full[0];
    assign bus.q1_full        = w_full[1];
    assign bus.q0_ovf         = w_ovf[0];
    assign bus.q1_ovf         = w_ovf[1];
    assign bus.mpq_data_valid = r_data_valid;
    assign bus.mpq_data       = r_data;
    assign bus.mpq_cmd_valid  = (r_state == S_ISSUE);
    assign bus.mpq_cmd        = r_cmd;
    assign bus.mpq_index      = r_index;
    assign bus.mpq_value      = r_value;
    assign bus.grant_src      = r_grant;
    assign bus.finished       = (r_state == S_FINISHED);
endmodule
`default_nettype wire

// File: tb/tb_mpq_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_mpq_sched : scoreboard bench for mpq_sched with a small engine model |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module tb_mpq_sched;
    logic clk = 1'b0;
    logic rst;
    logic hold_busy;
    int   eng_cnt;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_strobes = 0;
    int   push_cyc;
    logic [19:0] exp_q[$];
    logic [7:0]  ld_q[$];
    int          strobe_cyc[$];
    logic [7:0]  beats[5] = '{8'd8, 8'd3, 8'd9, 8'd1, 8'd7};

    mpq_sched_if bus();

    mpq_sched #(.FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine stays busy for three cycles after each strobe; hold_busy stretches it.
    always @(posedge clk) begin
        if (rst)
            eng_cnt <= 0;
        else if (bus.mpq_cmd_valid)
            eng_cnt <= 3;
        else if (eng_cnt > 0)
            eng_cnt <= eng_cnt - 1;
    end
    assign bus.mpq_busy = hold_busy || (eng_cnt != 0);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.mpq_cmd_valid) begin
            n_strobes++;
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0)
                chk("unexpected_strobe", 1, 0);
            else
                chk("issued_cmd", {bus.grant_src, bus.mpq_cmd, bus.mpq_index, bus.mpq_value},
                    exp_q.pop_front());
            chk("busy_at_issue", bus.mpq_busy, 0);
        end
        if (!rst && bus.mpq_data_valid) begin
            if (ld_q.size() == 0)
                chk("unexpected_data", 1, 0);
            else
                chk("ld_data", bus.mpq_data, ld_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_push();
        bus.q0_push = 0; bus.q0_cmd = 0; bus.q0_index = 0; bus.q0_value = 0;
        bus.q1_push = 0; bus.q1_cmd = 0; bus.q1_index = 0; bus.q1_value = 0;
    endtask

    task automatic set_push(input int q, input logic [2:0] c, input logic [7:0] i,
                            input logic [7:0] v, input bit issues);
        if (q == 0) begin
            bus.q0_push = 1; bus.q0_cmd = c; bus.q0_index = i; bus.q0_value = v;
        end else begin
            bus.q1_push = 1; bus.q1_cmd = c; bus.q1_index = i; bus.q1_value = v;
        end
        if (issues)
            exp_q.push_back({q[0], c, i, v});
    endtask

    task automatic wait_strobes(input int target, input string tag);
        int k = 0;
        while (n_strobes < target && k < 200) begin
            tick();
            k++;
        end
        chk(tag, n_strobes >= target, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {bus.q0_full, bus.q1_full, bus.q0_ovf, bus.q1_ovf, bus.finished,
                  bus.grant_src, bus.mpq_data_valid, bus.mpq_cmd_valid, bus.mpq_data,
                  bus.mpq_cmd, bus.mpq_index, bus.mpq_value}, 0);
    endtask

    task automatic load_beat(input logic [7:0] b);
        bus.ld_valid = 1; bus.ld_data = b; ld_q.push_back(b);
        tick();
        bus.ld_valid = 0;
        repeat (2) tick();
    endtask

    initial begin
        rst = 1; hold_busy = 0;
        bus.ld_valid = 0; bus.ld_data = 0; bus.mpq_done = 0;
        clr_push();
        repeat (2) tick();
        chk_zero("reset_outputs");
        rst = 0;

        // Loader beats echo one cycle later, then LOAD hands over to IDLE.
        foreach (beats[k]) begin
            bus.ld_valid = 1; bus.ld_data = beats[k]; ld_q.push_back(beats[k]);
            tick();
        end
        bus.ld_valid = 0;
        repeat (2) tick();
        chk("ld_drained", ld_q.size(), 0);

        // Simultaneous pushes: q0 first after reset, q1 after busy falls.
        set_push(0, 3'd0, 8'h01, 8'h02, 1);
        set_push(1, 3'd0, 8'h03, 8'h04, 1);
        push_cyc = cyc;
        tick();
        clr_push();
        wait_strobes(2, "t037_issue_timeout");
        chk("t037_latency", strobe_cyc[0] - push_cyc, 2);
        chk("t037_gap", strobe_cyc[1] - strobe_cyc[0], 6);
        repeat (10) tick();

        // Overflow: fifth push into a depth-4 FIFO is dropped.
        hold_busy = 1;
        for (int k = 0; k < 5; k++) begin
            set_push(0, (k % 2 == 1) ? 3'd2 : 3'd1, 8'(16 + k), 8'(32 + k), k < 4);
            tick();
            chk("t038_full", bus.q0_full, k >= 3);
            chk("t038_ovf", bus.q0_ovf, k == 4);
        end
        clr_push();
        tick();
        chk("t038_q1_ovf", bus.q1_ovf, 0);
        hold_busy = 0;
        wait_strobes(6, "t038_issue_timeout");
        repeat (10) tick();
        chk("t038_drained_full", bus.q0_full, 0);

        // Both pending after q0 was granted last: q1 wins this round.
        set_push(1, 3'd1, 8'h50, 8'h51, 1);
        set_push(0, 3'd2, 8'h40, 8'h41, 1);
        tick();
        clr_push();
        wait_strobes(8, "t_rr_issue_timeout");
        repeat (10) tick();

        // Insert from q1: single strobe, fields held afterwards.
        set_push(1, 3'd3, 8'h00, 8'h20, 1);
        tick();
        clr_push();
        wait_strobes(9, "t039_issue_timeout");
        repeat (10) tick();
        chk("t039_strobes", n_strobes, 9);
        chk("t039_hold_fields", {bus.mpq_cmd_valid, bus.mpq_cmd, bus.mpq_index, bus.mpq_value},
            {1'b0, 3'd3, 8'h00, 8'h20});

        // Write-out: finish on mpq_done, then inert.
        set_push(0, 3'd4, 8'h05, 8'h06, 1);
        tick();
        clr_push();
        wait_strobes(10, "t040_issue_timeout");
        repeat (8) tick();
        chk("t040_not_finished", bus.finished, 0);
        bus.mpq_done = 1;
        tick();
        bus.mpq_done = 0;
        chk("t040_finished", bus.finished, 1);
        for (int k = 0; k < 5; k++) begin
            set_push(1, 3'd0, 8'(k), 8'(k), 0);
            set_push(0, 3'd1, 8'(k), 8'(k), 0);
            bus.ld_valid = 1; bus.ld_data = 8'(k + 100);
            tick();
        end
        clr_push();
        bus.ld_valid = 0;
        repeat (10) tick();
        chk("t040_q1_full", bus.q1_full, 0);
        chk("t040_q1_ovf", bus.q1_ovf, 0);
        chk("t040_q0_ovf_sticky", bus.q0_ovf, 1);
        chk("t040_still_finished", bus.finished, 1);
        chk("t040_strobes", n_strobes, 10);

        // Reset during WAIT_LO with two entries in each FIFO.
        rst = 1;
        tick();
        rst = 0;
        load_beat(8'h5A);
        set_push(0, 3'd1, 8'h11, 8'h12, 1);
        tick();
        clr_push();
        wait_strobes(11, "t041_issue_timeout");
        hold_busy = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            set_push(0, 3'd2, 8'(8'h21 + k), 8'h22, 0);
            set_push(1, 3'd2, 8'(8'h31 + k), 8'h32, 0);
            tick();
        end
        clr_push();
        tick();
        rst = 1;
        tick();
        chk_zero("t041_reset_outputs");
        hold_busy = 0;
        rst = 0;
        load_beat(8'h33);
        repeat (12) tick();
        chk("t041_fifos_empty", n_strobes, 11);
        set_push(0, 3'd0, 8'h61, 8'h62, 1);
        set_push(1, 3'd0, 8'h71, 8'h72, 1);
        tick();
        clr_push();
        wait_strobes(13, "t041_issue_timeout2");
        repeat (10) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("ld_queue_empty", ld_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
